// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared types and helpers for the device-side PS/2 keyboard transmitter.
//   ps2_tx_state_t : bit-level FSM states (IDLE, SETUP, LOW, GAP)
//   PS2_FRAME_BITS : bits per PS/2 frame (start + 8 data + parity + stop)
//   odd_parity()   : parity bit that makes the 9-bit data+parity field odd
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOW   = 2'd2,
        GAP   = 2'd3
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ----------------------------------------------------------------------------
// ps2_tx_fifo
// Small synchronous first-word fall-through FIFO for scancode bytes.
//   clk, reset : system clock, synchronous active-high reset
//   push, din  : write request and byte; ignored while full, even when a pop
//                happens in the same cycle
//   pop, dout  : read request; dout is valid whenever empty is low
//   full/empty : registered status flags derived from the next occupancy
//   level      : current occupancy, 0 .. 2**AW
// ----------------------------------------------------------------------------
module ps2_tx_fifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok;
    logic          pop_ok;

    // Qualify against the registered flags so a full FIFO never takes a
    // write, regardless of a concurrent pop.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// ----------------------------------------------------------------------------
// ps2_kbd_tx
// Device-side PS/2 keyboard transmitter. Bytes are queued in a small FIFO and
// sent as 11-bit PS/2 frames (start 0, data LSB first, odd parity, stop 1)
// with a generated bus clock, followed by an idle gap.
//   clk_sys, reset : only clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready : byte input handshake
//   ps2_clk, ps2_data         : bus lines, straight from flops, idle high
//   busy        : frame or gap in progress, or bytes still queued
//   fifo_level  : FIFO occupancy
//   dbg_state   : current FSM state, for observation only
//
// Handshake: a byte is transferred on every clk_sys rising edge where
// tx_valid and tx_ready are both high; tx_ready depends only on FIFO
// occupancy, never on tx_valid, and the source holds tx_data while waiting.
// ----------------------------------------------------------------------------
module ps2_kbd_tx #(
    parameter int CLK_DIV = 720,
    parameter int GAP     = 1800,
    parameter int FIFO_AW = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   ps2_clk,
    output logic                   ps2_data,
    output logic                   busy,
    output logic [FIFO_AW:0]       fifo_level,
    output ps2_pkg::ps2_tx_state_t dbg_state
);

    import ps2_pkg::*;

    localparam int HALF_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP - 1);
    localparam logic [3:0]        LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t     state_q, state_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [10:0]       shift_q, shift_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              ps2_clk_q, ps2_clk_d;
    logic              ps2_data_q, ps2_data_d;

    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    ps2_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk_sys),
        .reset (reset),
        .push  (tx_valid),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Counters count down from their load value and advance the FSM at zero,
    // so each state lasts exactly CLK_DIV (or GAP) cycles including entry.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = {1'b1, odd_parity(fifo_dout), fifo_dout, 1'b0};
                    bit_idx_d  = '0;
                    half_cnt_d = HALF_LOAD;
                    ps2_data_d = 1'b0;  // start bit goes out on the pop edge
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                if (half_cnt_q == '0) begin
                    ps2_clk_d  = 1'b0;
                    half_cnt_d = HALF_LOAD;
                    state_d    = LOW;
                end else begin
                    half_cnt_d = half_cnt_q - 1'b1;
                end
            end

            LOW: begin
                if (half_cnt_q == '0) begin
                    ps2_clk_d = 1'b1;
                    if (bit_idx_q < LAST_BIT) begin
                        // Next bit changes together with the clock rising,
                        // so data only ever moves while the clock is high.
                        bit_idx_d  = bit_idx_q + 4'd1;
                        shift_d    = {1'b1, shift_q[10:1]};
                        ps2_data_d = shift_q[1];
                        half_cnt_d = HALF_LOAD;
                        state_d    = SETUP;
                    end else begin
                        ps2_data_d = 1'b1;
                        gap_cnt_d  = GAP_LOAD;
                        state_d    = ps2_pkg::GAP;
                    end
                end else begin
                    half_cnt_d = half_cnt_q - 1'b1;
                end
            end

            ps2_pkg::GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '1;
            bit_idx_q  <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

    assign ps2_clk   = ps2_clk_q;
    assign ps2_data  = ps2_data_q;
    assign tx_ready  = ~fifo_full;
    // Drops on the cycle IDLE is entered with nothing queued.
    assign busy      = (state_q != IDLE) | ~fifo_empty;
    assign dbg_state = state_q;

endmodule
